// File: rtl/button_conditioner.sv
// ============================================================================
// Module   : button_conditioner
// Purpose  : Synchronise and debounce a raw push-button, then classify each
//            press as short or long (and optionally detect double clicks).
// Options  : DOUBLE_CLICK_EN -- enables the double-click gap detector.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 240_000,
    parameter int LONG_CYCLES     = 12_000_000,
    parameter int DCLICK_CYCLES   = 3_600_000
) (
    input  logic CLK,
    input  logic RST,
    input  logic BTN,
    output logic BTN_LEVEL,
    output logic PRESS,
    output logic RELEASE,
    output logic SHORT_PRESS,
    output logic LONG_PRESS,
    output logic DOUBLE_CLICK
);

    localparam logic [23:0] c_DEB_LAST  = 24'(DEBOUNCE_CYCLES - 1);
    localparam logic [23:0] c_LONG_LAST = 24'(LONG_CYCLES - 1);

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_HELD      = 2'd1;
    localparam logic [1:0] c_LONG_HELD = 2'd2;

    if (DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 1 || DEBOUNCE_CYCLES >= (1 << 24) ||
        LONG_CYCLES >= (1 << 24) || DCLICK_CYCLES >= (1 << 24)) begin : g_param_check
        $error("button_conditioner: cycle parameters out of range");
    end

    logic        r_sync1;
    logic        r_sync2;
    logic [23:0] r_deb_cnt;
    logic [1:0]  r_state;
    logic [23:0] r_hold_cnt;

    logic w_toggle;
    logic w_rise;
    logic w_fall;
    logic w_long_qual;

    assign w_toggle    = (r_sync2 != BTN_LEVEL) && (r_deb_cnt == c_DEB_LAST);
    assign w_rise      = w_toggle & ~BTN_LEVEL;
    assign w_fall      = w_toggle &  BTN_LEVEL;
    assign w_long_qual = (r_state == c_HELD) && (r_hold_cnt == c_LONG_LAST);

    // Synchroniser and debounce counter; any matching cycle restarts the count.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_deb_cnt <= '0;
            BTN_LEVEL <= 1'b0;
            PRESS     <= 1'b0;
            RELEASE   <= 1'b0;
        end else begin
            r_sync1 <= BTN;
            r_sync2 <= r_sync1;
            PRESS   <= w_rise;
            RELEASE <= w_fall;
            if (r_sync2 != BTN_LEVEL) begin
                if (w_toggle) begin
                    BTN_LEVEL <= ~BTN_LEVEL;
                    r_deb_cnt <= '0;
                end else begin
                    r_deb_cnt <= r_deb_cnt + 24'd1;
                end
            end else begin
                r_deb_cnt <= '0;
            end
        end
    end

    // Release is tested before long-qualify so a coincident release wins.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= c_IDLE;
            r_hold_cnt  <= '0;
            SHORT_PRESS <= 1'b0;
            LONG_PRESS  <= 1'b0;
        end else begin
            SHORT_PRESS <= 1'b0;
            LONG_PRESS  <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    r_hold_cnt <= '0;
                    if (w_rise) r_state <= c_HELD;
                end
                c_HELD: begin
                    if (w_fall) begin
                        r_state     <= c_IDLE;
                        r_hold_cnt  <= '0;
                        SHORT_PRESS <= 1'b1;
                    end else if (w_long_qual) begin
                        r_state    <= c_LONG_HELD;
                        r_hold_cnt <= r_hold_cnt + 24'd1;
                        LONG_PRESS <= 1'b1;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 24'd1;
                    end
                end
                c_LONG_HELD: begin
                    if (w_fall) begin
                        r_state    <= c_IDLE;
                        r_hold_cnt <= '0;
                    end
                end
                default: begin
                    r_state    <= c_IDLE;
                    r_hold_cnt <= '0;
                end
            endcase
        end
    end

`ifdef DOUBLE_CLICK_EN
    localparam logic [23:0] c_DCLICK_LAST = 24'(DCLICK_CYCLES - 1);

    logic        r_armed;
    logic        r_second;
    logic [23:0] r_gap_cnt;
    logic        w_short;
    logic        w_long_ev;

    assign w_short   = (r_state == c_HELD) && w_fall;
    assign w_long_ev = w_long_qual && !w_fall;

    // r_second marks a second press that began inside the gap window.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_armed      <= 1'b0;
            r_second     <= 1'b0;
            r_gap_cnt    <= '0;
            DOUBLE_CLICK <= 1'b0;
        end else begin
            DOUBLE_CLICK <= 1'b0;
            if (w_short) begin
                if (r_second) begin
                    DOUBLE_CLICK <= 1'b1;
                    r_armed      <= 1'b0;
                    r_second     <= 1'b0;
                end else begin
                    r_armed   <= 1'b1;
                    r_gap_cnt <= '0;
                end
            end else if (r_second) begin
                if (w_long_ev) begin
                    r_armed  <= 1'b0;
                    r_second <= 1'b0;
                end
            end else if (r_armed) begin
                if (w_rise) begin
                    r_second <= 1'b1;
                end else if (r_gap_cnt == c_DCLICK_LAST) begin
                    r_armed <= 1'b0;
                end else begin
                    r_gap_cnt <= r_gap_cnt + 24'd1;
                end
            end
        end
    end
`else
    assign DOUBLE_CLICK = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_button_conditioner.sv
// ============================================================================
// Module   : tb_button_conditioner
// Purpose  : Directed self-checking bench for button_conditioner (4/20/10).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_button_conditioner;

    logic CLK = 1'b0;
    logic RST;
    logic BTN;
    logic BTN_LEVEL, PRESS, RELEASE, SHORT_PRESS, LONG_PRESS, DOUBLE_CLICK;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int n_press, n_release, n_short, n_long, n_dc;
    int t_press, t_release, t_short, t_long, t_dc;
    int t_mark, t_mark2;

    button_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES    (20),
        .DCLICK_CYCLES  (10)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .BTN         (BTN),
        .BTN_LEVEL   (BTN_LEVEL),
        .PRESS       (PRESS),
        .RELEASE     (RELEASE),
        .SHORT_PRESS (SHORT_PRESS),
        .LONG_PRESS  (LONG_PRESS),
        .DOUBLE_CLICK(DOUBLE_CLICK)
    );

    always #5 CLK = ~CLK;

    task automatic clear_counts();
        n_press = 0; n_release = 0; n_short = 0; n_long = 0; n_dc = 0;
        t_press = -1; t_release = -1; t_short = -1; t_long = -1; t_dc = -1;
    endtask

    // Advance n cycles, sampling 1 time unit after each rising edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
            cyc++;
            if (PRESS)        begin n_press++;   t_press   = cyc; end
            if (RELEASE)      begin n_release++; t_release = cyc; end
            if (SHORT_PRESS)  begin n_short++;   t_short   = cyc; end
            if (LONG_PRESS)   begin n_long++;    t_long    = cyc; end
            if (DOUBLE_CLICK) begin n_dc++;      t_dc      = cyc; end
        end
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, ".level"}, int'(BTN_LEVEL), 0);
        check({tag, ".press"}, int'(PRESS), 0);
        check({tag, ".release"}, int'(RELEASE), 0);
        check({tag, ".short"}, int'(SHORT_PRESS), 0);
        check({tag, ".long"}, int'(LONG_PRESS), 0);
        check({tag, ".dclick"}, int'(DOUBLE_CLICK), 0);
    endtask

    initial begin
        RST = 1'b1;
        BTN = 1'b0;
        clear_counts();
        tick(3);
        check_outputs_zero("reset");
        RST = 1'b0;
        tick(3);
        check_outputs_zero("post_reset");

        // Bounce: toggling every 2 cycles never survives the 4-cycle filter.
        clear_counts();
        for (int i = 0; i < 15; i++) begin
            BTN = ~BTN;
            tick(2);
        end
        BTN = 1'b0;
        tick(12);
        check("bounce.level", int'(BTN_LEVEL), 0);
        check("bounce.pulses", n_press + n_release + n_short + n_long + n_dc, 0);

        // Short press: 12 cycles high.
        clear_counts();
        BTN = 1'b1; t_mark = cyc;
        tick(12);
        check("short.level_high", int'(BTN_LEVEL), 1);
        BTN = 1'b0; t_mark2 = cyc;
        tick(15);
        check("short.n_press", n_press, 1);
        check("short.press_lat", t_press - t_mark, 6);
        check("short.n_release", n_release, 1);
        check("short.release_lat", t_release - t_mark2, 6);
        check("short.n_short", n_short, 1);
        check("short.short_with_release", t_short, t_release);
        check("short.n_long", n_long, 0);
        check("short.level_low", int'(BTN_LEVEL), 0);

        // Long press: 50 cycles high.
        clear_counts();
        BTN = 1'b1; t_mark = cyc;
        tick(50);
        BTN = 1'b0; t_mark2 = cyc;
        tick(15);
        check("long.n_press", n_press, 1);
        check("long.press_lat", t_press - t_mark, 6);
        check("long.n_long", n_long, 1);
        check("long.long_lat", t_long - t_press, 20);
        check("long.n_release", n_release, 1);
        check("long.release_lat", t_release - t_mark2, 6);
        check("long.n_short", n_short, 0);

        // Two 8-cycle presses, 6-cycle gap.
        clear_counts();
        BTN = 1'b1; tick(8);
        BTN = 1'b0; tick(6);
        BTN = 1'b1; tick(8);
        BTN = 1'b0; tick(15);
        check("dc_near.n_press", n_press, 2);
        check("dc_near.n_short", n_short, 2);
`ifdef DOUBLE_CLICK_EN
        check("dc_near.n_dclick", n_dc, 1);
        check("dc_near.dclick_with_short", t_dc, t_short);
`else
        check("dc_near.n_dclick", n_dc, 0);
`endif

        // Two 8-cycle presses, 16-cycle gap: outside the window.
        clear_counts();
        BTN = 1'b1; tick(8);
        BTN = 1'b0; tick(16);
        BTN = 1'b1; tick(8);
        BTN = 1'b0; tick(15);
        check("dc_far.n_short", n_short, 2);
        check("dc_far.n_dclick", n_dc, 0);

        // Reset 10 cycles into a hold, button kept down.
        clear_counts();
        BTN = 1'b1;
        tick(6);
        check("rst_hold.first_press", n_press, 1);
        tick(9);
        RST = 1'b1;
        tick(1);
        check_outputs_zero("rst_hold.after_rst");
        RST = 1'b0; t_mark = cyc;
        clear_counts();
        tick(12);
        check("rst_hold.n_press", n_press, 1);
        check("rst_hold.press_lat", t_press - t_mark, 6);
        check("rst_hold.n_release", n_release, 0);
        check("rst_hold.n_short", n_short, 0);
        check("rst_hold.n_long", n_long, 0);
        check("rst_hold.level", int'(BTN_LEVEL), 1);
        BTN = 1'b0;
        tick(10);
        check("rst_hold.final_short", n_short, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter: DEBOUNCE_CYCLES, 240_000, consecutive stable cycles required to accept a BTN change (20 ms at 12 MHz).
REQ-002 SHALL have parameter: LONG_CYCLES, 12_000_000, hold duration in cycles that qualifies a long press (1 s at 12 MHz).
REQ-003 SHALL have parameter: DCLICK_CYCLES, 3_600_000, maximum gap in cycles from SHORT_PRESS to the next PRESS for a double click (300 ms).
REQ-004 SHALL have port: CLK  input  1  system clock (12 MHz).
REQ-005 SHALL have port: RST  input  1  reset; synchronous and active-high.
REQ-006 SHALL have port: BTN  input  1  raw asynchronous button, 1 = pressed, bouncing.
REQ-007 SHALL have port: BTN_LEVEL  output  1  debounced button level, 1 = pressed.
REQ-008 SHALL have ports: PRESS and RELEASE, each output 1, one-cycle pulse on a BTN_LEVEL rise or fall.
REQ-009 SHALL have ports: SHORT_PRESS and LONG_PRESS, each output 1, one-cycle press-classification pulse.
REQ-010 SHALL have port: DOUBLE_CLICK  output  1  one-cycle pulse; constant 0 when the feature is compiled out.

Function
REQ-011 SHALL pass BTN through a 2-flop synchronizer before any other logic.
REQ-012 SHALL count consecutive cycles where the synchronized BTN differs from BTN_LEVEL; the count clears on any cycle where they match.
REQ-013 SHALL toggle BTN_LEVEL and clear the count on the edge where a differing count equals DEBOUNCE_CYCLES-1; total BTN-to-BTN_LEVEL latency is DEBOUNCE_CYCLES+2 cycles.
REQ-014 SHALL assert PRESS in the first cycle BTN_LEVEL=1 and RELEASE in the first cycle BTN_LEVEL=0, one cycle each.
REQ-015 SHALL implement FSM IDLE, HELD, LONG_HELD: IDLE->HELD on PRESS; HELD->LONG_HELD on long qualify; HELD->IDLE on RELEASE; LONG_HELD->IDLE on RELEASE.
REQ-016 SHALL keep a hold counter: 0 in IDLE, incrementing each HELD cycle, and saturating (no wrap) once LONG_HELD is reached.
REQ-017 SHALL pulse LONG_PRESS once, exactly LONG_CYCLES cycles after the PRESS cycle, if BTN_LEVEL is still 1; it never repeats while held.
REQ-018 SHALL pulse SHORT_PRESS in the RELEASE cycle only when leaving HELD; a release from LONG_HELD produces RELEASE only.
REQ-019 SHALL give release precedence when release and long qualify fall in the same cycle: SHORT_PRESS, no LONG_PRESS.
REQ-020 SHALL size counters at 24 bits; parameters SHALL satisfy 1 <= DEBOUNCE_CYCLES and LONG_CYCLES, DCLICK_CYCLES < 2^24.
REQ-021 SHALL register all outputs; none is combinational from BTN.

Reset
REQ-022 SHALL clear on RST=1 at a CLK edge: synchronizer, counters, BTN_LEVEL, and all pulse outputs to 0, and FSM to IDLE.
REQ-023 SHALL abort a press in progress on reset mid-hold with no RELEASE/SHORT_PRESS/LONG_PRESS; a button still held after RST deasserts produces PRESS after DEBOUNCE_CYCLES+2 cycles.

Configuration
REQ-024 SHALL, when DOUBLE_CLICK_EN is defined, arm a gap counter on each SHORT_PRESS; if PRESS occurs within DCLICK_CYCLES cycles and that press ends in SHORT_PRESS, it SHALL pulse DOUBLE_CLICK in the same cycle as that SHORT_PRESS and disarm.
REQ-025 SHALL disarm without DOUBLE_CLICK on gap expiry, or on a LONG_PRESS during the second press.
REQ-026 SHALL, when DOUBLE_CLICK_EN is undefined, tie DOUBLE_CLICK to 0 and synthesize no gap-counter logic; all other behaviour is identical.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=20, DCLICK_CYCLES=10)
REQ-027 SHALL cover: BTN toggled every 2 cycles for 30 cycles, then 0 -> BTN_LEVEL stays 0; no pulses.
REQ-028 SHALL cover: BTN=1 for 12 cycles, then 0 -> PRESS 6 cycles after the rise; RELEASE+SHORT_PRESS together 6 cycles after the fall; no LONG_PRESS.
REQ-029 SHALL cover: BTN=1 for 50 cycles -> a single LONG_PRESS 20 cycles after PRESS; at release, RELEASE only, no SHORT_PRESS.
REQ-030 SHALL cover, with DOUBLE_CLICK_EN: two 8-cycle presses with gap 6 give DOUBLE_CLICK with the 2nd SHORT_PRESS; a gap of 16 gives none; without the macro, DOUBLE_CLICK stays 0.
REQ-031 SHALL cover: RST pulsed 1 cycle, 10 cycles after PRESS, with BTN held -> all outputs 0 next cycle; PRESS again 6 cycles after RST deasserts; no spurious RELEASE.
